// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between the execute stage and the multiply/divide unit
interface mdu_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] inA;
  logic [31:0] inB;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, op, inA, inB, input busy, done, hi, lo);
  modport slave (input start, op, inA, inB, output busy, done, hi, lo);
endinterface

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with HI/LO pair, result held pending until the cycle count expires
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset_n,
  mdu_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] phi_q, phi_d, plo_q, plo_d, hi_q, hi_d, lo_q, lo_d;
  logic dz_q, dz_d, done_q, done_d;
  logic [63:0] prod_s, prod_u;
  logic [31:0] divisor, q_s, r_s, q_u, r_u;
  logic dz, ovf, is_mul, is_div, go;
  always_comb begin
    prod_s = {{32{bus.inA[31]}}, bus.inA} * {{32{bus.inB[31]}}, bus.inB};
    prod_u = {32'b0, bus.inA} * {32'b0, bus.inB};
    dz = bus.inB == '0;
    ovf = bus.inA == 32'h8000_0000 && bus.inB == '1;
    // dividing by one yields the required overflow result and keeps div-by-zero defined
    divisor = (dz || ovf) ? 32'd1 : bus.inB;
    q_s = $signed(bus.inA) / $signed(divisor);
    r_s = $signed(bus.inA) % $signed(divisor);
    q_u = bus.inA / divisor;
    r_u = bus.inA % divisor;
    is_mul = bus.op == 4'd1 || bus.op == 4'd2;
    is_div = bus.op == 4'd3 || bus.op == 4'd4;
    go = state_q == IDLE && bus.start;
    state_d = state_q;
    cnt_d = cnt_q;
    phi_d = phi_q;
    plo_d = plo_q;
    hi_d = hi_q;
    lo_d = lo_q;
    dz_d = dz_q;
    done_d = 1'b0;
    if (go && (is_mul || is_div)) begin
      state_d = RUN;
      cnt_d = is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
      dz_d = is_div && dz;
      phi_d = bus.op == 4'd1 ? prod_s[63:32] : bus.op == 4'd2 ? prod_u[63:32] : bus.op == 4'd3 ? r_s : r_u;
      plo_d = bus.op == 4'd1 ? prod_s[31:0] : bus.op == 4'd2 ? prod_u[31:0] : bus.op == 4'd3 ? q_s : q_u;
    end else if (go) begin
      hi_d = bus.op == 4'd5 ? bus.inA : hi_q;
      lo_d = bus.op == 4'd6 ? bus.inA : lo_q;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = IDLE;
        done_d = 1'b1;
        hi_d = dz_q ? hi_q : phi_q;
        lo_d = dz_q ? lo_q : plo_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      phi_q <= '0;
      plo_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      dz_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      phi_q <= phi_d;
      plo_q <= plo_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      dz_q <= dz_d;
      done_q <= done_d;
    end
  end
  assign bus.busy = state_q == RUN;
  assign bus.done = done_q;
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
endmodule
